// File: rtl/mem_pkg.sv
// Shared constants for the unified memory: RV32I width codes, arbiter state
// encoding, byte-lane helpers and the misalignment rule.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RESP_I = 2'd1;
    localparam logic [1:0] ST_RESP_D = 2'd2;

    localparam int         BYTE_W    = 8;
    localparam int         HALF_W    = 16;
    localparam logic [1:0] LANE_MASK = 2'b11;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
        case (funct3)
            F3_H, F3_HU: return lane[0];
            F3_W:        return lane != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load extractor: picks the byte/halfword lane out of a raw little-endian word
// and sign- or zero-extends it according to funct3.
module mem_load_ext
    import mem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [BYTE_W-1:0] sel_b;
    logic [HALF_W-1:0] sel_h;

    always_comb begin
        sel_b  = raw[{lane, 3'b000} +: BYTE_W];
        sel_h  = raw[{lane[1], 4'b0000} +: HALF_W];
        result = '0;
        case (funct3)
            F3_B:    result = {{24{sel_b[BYTE_W-1]}}, sel_b};
            F3_BU:   result = {24'h0, sel_b};
            F3_H:    result = {{16{sel_h[HALF_W-1]}}, sel_h};
            F3_HU:   result = {16'h0, sel_h};
            F3_W:    result = raw;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/unified_mem_arb.sv
// Single-ported byte memory shared by fetch and data ports through a one-grant-
// per-cycle arbiter. Optional starvation guard: UNIFIED_MEM_STARVE_GUARD_EN.
//
//   state     | meaning
//   IDLE      | no response in flight
//   RESP_I    | instruction response in flight
//   RESP_D    | data response in flight
module unified_mem_arb
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int DATA_BASE  = 2048,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_valid,
    output logic              i_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_funct3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              d_misalign
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [1:0]        state, state_nxt;
    logic              grant_i, grant_d, starve_force;
    logic [ADDR_W-1:0] i_ea, d_ea;
    logic [31:0]       i_word, d_word, d_ext;
    logic              d_mis;

    assign i_ea  = i_addr & ~ADDR_W'(LANE_MASK);
    assign d_ea  = d_addr + ADDR_W'(DATA_BASE);
    assign d_mis = is_misaligned(d_funct3, d_ea[1:0]);

    assign i_word = {mem[{i_ea[ADDR_W-1:2], 2'd3}], mem[{i_ea[ADDR_W-1:2], 2'd2}],
                     mem[{i_ea[ADDR_W-1:2], 2'd1}], mem[{i_ea[ADDR_W-1:2], 2'd0}]};
    assign d_word = {mem[{d_ea[ADDR_W-1:2], 2'd3}], mem[{d_ea[ADDR_W-1:2], 2'd2}],
                     mem[{d_ea[ADDR_W-1:2], 2'd1}], mem[{d_ea[ADDR_W-1:2], 2'd0}]};

    mem_load_ext u_load_ext (
        .raw    (d_word),
        .lane   (d_ea[1:0]),
        .funct3 (d_funct3),
        .result (d_ext)
    );

`ifdef UNIFIED_MEM_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign starve_force = (starve_cnt >= CNT_W'(STARVE_MAX)) && i_req && (state != ST_RESP_I);

    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (grant_i || !i_req)
            starve_cnt <= '0;
        else if (grant_d && (starve_cnt < CNT_W'(STARVE_MAX)))
            starve_cnt <= starve_cnt + 1'b1;
    end
`else
    // Guard compiled out; the expression is constant false for any legal STARVE_MAX.
    assign starve_force = (STARVE_MAX < 0);
`endif

    // The port whose response is in flight sits out one cycle.
    assign grant_d = d_req && (state != ST_RESP_D) && !starve_force;
    assign grant_i = i_req && (state != ST_RESP_I) && !grant_d;
    assign i_stall = i_req && !grant_i;
    assign d_stall = d_req && !grant_d;

    always_comb begin
        state_nxt = ST_IDLE;
        if (grant_d)
            state_nxt = ST_RESP_D;
        else if (grant_i)
            state_nxt = ST_RESP_I;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            d_misalign <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            i_valid    <= grant_i;
            d_valid    <= grant_d;
            d_misalign <= grant_d && d_mis;
            if (grant_i)
                i_rdata <= i_word;
            if (grant_d)
                d_rdata <= (d_we || d_mis) ? '0 : d_ext;
        end
    end

    // Array contents survive reset; a store coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && grant_d && d_we && !d_mis) begin
            case (d_funct3)
                F3_B: mem[d_ea] <= d_wdata[7:0];
                F3_H: begin
                    mem[{d_ea[ADDR_W-1:1], 1'b0}] <= d_wdata[7:0];
                    mem[{d_ea[ADDR_W-1:1], 1'b1}] <= d_wdata[15:8];
                end
                F3_W: begin
                    mem[{d_ea[ADDR_W-1:2], 2'd0}] <= d_wdata[7:0];
                    mem[{d_ea[ADDR_W-1:2], 2'd1}] <= d_wdata[15:8];
                    mem[{d_ea[ADDR_W-1:2], 2'd2}] <= d_wdata[23:16];
                    mem[{d_ea[ADDR_W-1:2], 2'd3}] <= d_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arb.sv
// Bench for unified_mem_arb: a byte-array reference model checked every cycle,
// plus directed load/store/arbitration/reset vectors with literal expectations.
module tb_unified_mem_arb;

    localparam int ADDR_W     = 12;
    localparam int DATA_BASE  = 2048;
    localparam int STARVE_MAX = 2;
    localparam int DEPTH      = 4096;

    logic        clk, rst;
    logic        i_req;
    logic [11:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid, i_stall;
    logic        d_req, d_we;
    logic [2:0]  d_funct3;
    logic [11:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        d_valid, d_stall, d_misalign;

    unified_mem_arb #(.ADDR_W(ADDR_W), .DATA_BASE(DATA_BASE), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .i_stall(i_stall),
        .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall), .d_misalign(d_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_mem   [DEPTH];
    bit          m_known [DEPTH];
    int          busy_port;     // 0 none, 1 fetch, 2 data response in flight
    int          starve;
    bit          armed;
    logic        exp_iv, exp_dv, exp_mis;
    logic [31:0] exp_ir, exp_dr;
    bit          exp_ir_ok, exp_dr_ok;

    function automatic bit m_misaligned(input logic [2:0] f3, input int ea);
        if (f3 == 3'd1 || f3 == 3'd5) return (ea % 2) != 0;
        if (f3 == 3'd2)               return (ea % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_word(input int ea);
        return {m_mem[(ea + 3) % DEPTH], m_mem[(ea + 2) % DEPTH],
                m_mem[(ea + 1) % DEPTH], m_mem[ea % DEPTH]};
    endfunction

    function automatic bit m_known_n(input int ea, input int n);
        for (int k = 0; k < n; k++)
            if (!m_known[(ea + k) % DEPTH]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic m_load(input logic [2:0] f3, input int ea, output logic [31:0] v, output bit ok);
        logic [31:0] w;
        w = m_word(ea);
        case (f3)
            3'd0: begin v = {{24{w[7]}}, w[7:0]};    ok = m_known_n(ea, 1); end
            3'd4: begin v = {24'h0, w[7:0]};         ok = m_known_n(ea, 1); end
            3'd1: begin v = {{16{w[15]}}, w[15:0]};  ok = m_known_n(ea, 2); end
            3'd5: begin v = {16'h0, w[15:0]};        ok = m_known_n(ea, 2); end
            3'd2: begin v = w;                       ok = m_known_n(ea, 4); end
            default: begin v = 32'h0;                ok = 1'b1; end
        endcase
    endtask

    task automatic m_store(input logic [2:0] f3, input int ea, input logic [31:0] wd);
        int n;
        n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        for (int k = 0; k < n; k++) begin
            m_mem[(ea + k) % DEPTH]   = wd[8*k +: 8];
            m_known[(ea + k) % DEPTH] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        bit gd, gi, force_i, mis;
        int ea;
        logic [31:0] v;
        bit ok;
        if (armed) begin
            check("i_valid", i_valid, exp_iv);
            check("d_valid", d_valid, exp_dv);
            check("d_misalign", d_misalign, exp_mis);
            if (exp_iv && exp_ir_ok) check("i_rdata", i_rdata, exp_ir);
            if (exp_dv && exp_dr_ok) check("d_rdata", d_rdata, exp_dr);
        end
`ifdef UNIFIED_MEM_STARVE_GUARD_EN
        force_i = (starve >= STARVE_MAX) && i_req && (busy_port != 1);
`else
        force_i = 1'b0;
`endif
        gd = d_req && (busy_port != 2) && !force_i;
        gi = i_req && (busy_port != 1) && !gd;
        if (armed) begin
            check("i_stall", i_stall, i_req && !gi);
            check("d_stall", d_stall, d_req && !gd);
        end
        if (rst) begin
            busy_port = 0; starve = 0; armed = 1'b1;
            exp_iv = 0; exp_dv = 0; exp_mis = 0;
            exp_ir_ok = 0; exp_dr_ok = 0;
        end else if (armed) begin
            exp_iv = gi; exp_dv = gd; exp_mis = 0;
            exp_ir_ok = 0; exp_dr_ok = 0;
            if (gi) begin
                ea = int'(i_addr) & ~3;
                exp_ir = m_word(ea);
                exp_ir_ok = m_known_n(ea, 4);
            end
            if (gd) begin
                ea  = (int'(d_addr) + DATA_BASE) % DEPTH;
                mis = m_misaligned(d_funct3, ea);
                exp_mis = mis;
                if (d_we) begin
                    if (!mis) m_store(d_funct3, ea, d_wdata);
                end else if (mis) begin
                    exp_dr = 32'h0; exp_dr_ok = 1'b1;
                end else begin
                    m_load(d_funct3, ea, v, ok);
                    exp_dr = v; exp_dr_ok = ok;
                end
            end
            if (gi || !i_req) starve = 0;
            else if (gd) starve++;
            busy_port = gd ? 2 : (gi ? 1 : 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic d_op(input logic we, input logic [2:0] f3, input logic [11:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic mis);
        bit got;
        d_req = 1'b1; d_we = we; d_funct3 = f3; d_addr = a; d_wdata = wd;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(posedge clk); #1;
            got = d_valid;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL d_op_timeout: no d_valid for addr 0x%03h", a);
        end
        rd = d_rdata; mis = d_misalign;
        d_req = 1'b0;
    endtask

    task automatic i_op(input logic [11:0] a, output logic [31:0] rd);
        bit got;
        i_req = 1'b1; i_addr = a;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(posedge clk); #1;
            got = i_valid;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL i_op_timeout: no i_valid for addr 0x%03h", a);
        end
        rd = i_rdata;
        i_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        mis;
        longint      t0;
        armed = 1'b0; busy_port = 0; starve = 0;
        rst = 1'b1; i_req = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_funct3 = '0; d_addr = '0; d_wdata = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_i_valid", i_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_d_misalign", d_misalign, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        d_op(1, 3'd2, 12'd0, 32'h12345678, rd, mis);
        d_op(0, 3'd2, 12'd0, 0, rd, mis);        check("lw_base", rd, 32'h12345678);
        check("lw_base_mis", mis, 0);
        d_op(1, 3'd0, 12'd1, 32'h000000AB, rd, mis);
        d_op(0, 3'd2, 12'd0, 0, rd, mis);        check("lw_after_sb", rd, 32'h1234AB78);

        d_op(1, 3'd0, 12'd4, 32'h00000080, rd, mis);
        d_op(0, 3'd0, 12'd4, 0, rd, mis);        check("lb_neg", rd, 32'hFFFFFF80);
        d_op(0, 3'd4, 12'd4, 0, rd, mis);        check("lbu", rd, 32'h00000080);
        d_op(1, 3'd1, 12'd6, 32'h00008001, rd, mis);
        d_op(0, 3'd1, 12'd6, 0, rd, mis);        check("lh_neg", rd, 32'hFFFF8001);
        d_op(0, 3'd5, 12'd6, 0, rd, mis);        check("lhu", rd, 32'h00008001);
        d_op(1, 3'd0, 12'd5, 32'h00000011, rd, mis);

        d_op(1, 3'd2, 12'd2, 32'hDEADBEEF, rd, mis); check("sw_mis_flag", mis, 1);
        d_op(0, 3'd2, 12'd0, 0, rd, mis);        check("sw_mis_lo_intact", rd, 32'h1234AB78);
        d_op(0, 3'd2, 12'd4, 0, rd, mis);        check("sw_mis_hi_intact", rd, 32'h80011180);
        d_op(0, 3'd2, 12'd1, 0, rd, mis);        check("lw_mis_data", rd, 0);
        check("lw_mis_flag", mis, 1);
        d_op(0, 3'd1, 12'd3, 0, rd, mis);        check("lh_mis_flag", mis, 1);
        d_op(0, 3'd3, 12'd0, 0, rd, mis);        check("undef_f3_data", rd, 0);
        check("undef_f3_mis", mis, 0);

        // data address 2048 wraps onto byte 0, shared with the fetch port
        d_op(1, 3'd2, 12'd2048, 32'hCAFEF00D, rd, mis);
        i_op(12'd2, rd);                         check("fetch_wrap", rd, 32'hCAFEF00D);

        // reset in the grant cycle of a load
        idle(1);
        rst = 1'b1; d_req = 1'b1; d_we = 0; d_funct3 = 3'd2; d_addr = 12'd0;
        @(posedge clk); #1;
        check("rst_drop_valid", d_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_idle_grant", d_stall, 0);
        @(posedge clk); #1;
        check("post_rst_valid", d_valid, 1);
        check("post_rst_data", d_rdata, 32'h1234AB78);
        d_req = 1'b0;

        // store coinciding with reset is discarded
        idle(1);
        rst = 1'b1; d_req = 1'b1; d_we = 1; d_funct3 = 3'd0; d_addr = 12'd0; d_wdata = 32'hEE;
        @(posedge clk); #1;
        rst = 1'b0; d_req = 1'b0; d_we = 0;
        idle(1);
        d_op(0, 3'd2, 12'd0, 0, rd, mis);        check("rst_store_dropped", rd, 32'h1234AB78);

        // both ports held from reset release: D,I,D,I...
        idle(1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; i_req = 1'b1; i_addr = 12'd0;
        d_req = 1'b1; d_we = 0; d_funct3 = 3'd2; d_addr = 12'd2048;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("alt_i_stall_%0d", k), i_stall, (k % 2) == 0);
            check($sformatf("alt_d_stall_%0d", k), d_stall, (k % 2) == 1);
        end
        @(posedge clk); #1;
        i_req = 0; d_req = 0;

        // fetch held while data re-requests after each d_valid
        idle(2);
        i_req = 1'b1; i_addr = 12'd0;
        t0 = $time;
        repeat (3) d_op(0, 3'd2, 12'd0, 0, rd, mis);
        check("interleave_span", int'(($time - t0) / 10), 5);
        i_req = 1'b0;

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
